// File: rtl/adat_rx_lock_ctrl_if.sv
// Decoder/parser-side signal bundle for the ADAT frame-lock controller.
// The master drives decoder/parser events; the slave (lock controller) returns lock status.
interface adat_rx_lock_ctrl_if;
    logic        i_sync;
    logic        i_valid;
    logic [2:0]  i_bit_count;
    logic        i_data_valid;
    logic [2:0]  i_channel;
    logic        o_parser_sync;
    logic        o_locked;
    logic [1:0]  o_state;
    logic        o_frame_good;
    logic        o_frame_error;
    logic [15:0] o_err_count;

    modport master (
        output i_sync, i_valid, i_bit_count, i_data_valid, i_channel,
        input  o_parser_sync, o_locked, o_state, o_frame_good, o_frame_error, o_err_count
    );

    modport slave (
        input  i_sync, i_valid, i_bit_count, i_data_valid, i_channel,
        output o_parser_sync, o_locked, o_state, o_frame_good, o_frame_error, o_err_count
    );
endinterface

// File: rtl/adat_rx_lock_ctrl.sv
// ADAT receive frame-lock controller: restarts the parser on each sync, grades frames,
// and runs a SEARCH/VERIFY/LOCKED/HOLD state machine with hysteresis.
module adat_rx_lock_ctrl #(
    parameter int EXP_BITS       = 245,
    parameter int LOCK_FRAMES    = 4,
    parameter int UNLOCK_FRAMES  = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    adat_rx_lock_ctrl_if.slave    bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  good_cnt_q, good_cnt_d;
    logic [BW-1:0]  bad_cnt_q, bad_cnt_d;
    logic [8:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]     exp_ch_q, exp_ch_d;
    logic           order_err_q, order_err_d;
    logic [CW-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic           parser_sync_q;
    logic           locked_q, locked_d;
    logic           frame_good_q, frame_good_d;
    logic           frame_error_q, frame_error_d;
    logic [15:0]    err_count_q, err_count_d;

    logic           ch_hit, ch_bad;
    logic [3:0]     exp_ch_eff;
    logic           order_err_eff;
    logic           timeout;
    logic           evaluate;
    logic           frame_ok;
    logic [9:0]     bit_sum;
    logic [8:0]     bit_acc;

    // A channel word in the sync cycle still belongs to the frame being closed.
    assign ch_hit        = bus.i_data_valid && (exp_ch_q != 4'd8) && (bus.i_channel == exp_ch_q[2:0]);
    assign ch_bad        = bus.i_data_valid && !ch_hit;
    assign exp_ch_eff    = ch_hit ? exp_ch_q + 4'd1 : exp_ch_q;
    assign order_err_eff = order_err_q | ch_bad;

    assign timeout  = !bus.i_sync && (cyc_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign evaluate = (bus.i_sync || timeout) && (state_q != ST_SEARCH);
    assign frame_ok = (bit_cnt_q == 9'(EXP_BITS)) && (exp_ch_eff == 4'd8) && !order_err_eff;

    assign bit_sum = {1'b0, bit_cnt_q} + {7'd0, bus.i_bit_count};
    assign bit_acc = bit_sum[9] ? 9'h1FF : bit_sum[8:0];

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        exp_ch_d    = exp_ch_eff;
        order_err_d = order_err_eff;
        cyc_cnt_d   = cyc_cnt_q + CW'(1);
        if (bus.i_sync) begin
            // Bits arriving with the sync open the next frame.
            bit_cnt_d   = bus.i_valid ? {6'd0, bus.i_bit_count} : 9'd0;
            exp_ch_d    = 4'd0;
            order_err_d = 1'b0;
            cyc_cnt_d   = '0;
        end else if (timeout) begin
            bit_cnt_d   = 9'd0;
            exp_ch_d    = 4'd0;
            order_err_d = 1'b0;
            cyc_cnt_d   = '0;
        end else if (bus.i_valid) begin
            bit_cnt_d   = bit_acc;
        end
    end

    always_comb begin
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        frame_good_d  = 1'b0;
        frame_error_d = 1'b0;
        err_count_d   = err_count_q;

        if (evaluate) begin
            if (frame_ok) begin
                frame_good_d = 1'b1;
            end else begin
                frame_error_d = 1'b1;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end
        end

        case (state_q)
            ST_SEARCH: begin
                if (bus.i_sync) begin
                    state_d    = ST_VERIFY;
                    good_cnt_d = '0;
                end
            end
            ST_VERIFY: begin
                if (evaluate) begin
                    if (!frame_ok) begin
                        state_d = ST_SEARCH;
                    end else if (good_cnt_q + GW'(1) == GW'(LOCK_FRAMES)) begin
                        state_d = ST_LOCKED;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (evaluate && !frame_ok) begin
                    state_d   = ST_HOLD;
                    bad_cnt_d = BW'(1);
                end
            end
            ST_HOLD: begin
                if (evaluate) begin
                    if (frame_ok) begin
                        state_d   = ST_LOCKED;
                        bad_cnt_d = '0;
                    end else if (bad_cnt_q + BW'(1) == BW'(UNLOCK_FRAMES)) begin
                        state_d = ST_SEARCH;
                    end else begin
                        bad_cnt_d = bad_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= ST_SEARCH;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            bit_cnt_q     <= 9'd0;
            exp_ch_q      <= 4'd0;
            order_err_q   <= 1'b0;
            cyc_cnt_q     <= '0;
            parser_sync_q <= 1'b1;
            locked_q      <= 1'b0;
            frame_good_q  <= 1'b0;
            frame_error_q <= 1'b0;
            err_count_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            exp_ch_q      <= exp_ch_d;
            order_err_q   <= order_err_d;
            cyc_cnt_q     <= cyc_cnt_d;
            parser_sync_q <= ~bus.i_sync;
            locked_q      <= locked_d;
            frame_good_q  <= frame_good_d;
            frame_error_q <= frame_error_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.o_parser_sync = parser_sync_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_state       = state_q;
    assign bus.o_frame_good  = frame_good_q;
    assign bus.o_frame_error = frame_error_q;
    assign bus.o_err_count   = err_count_q;
endmodule

// File: tb/tb_adat_rx_lock_ctrl.sv
// Self-checking bench for adat_rx_lock_ctrl: table of frames closed by sync, with
// expected close results queued at the sync and checked once the registered outputs appear.
module tb_adat_rx_lock_ctrl;
    logic i_clk;
    logic i_rst;

    adat_rx_lock_ctrl_if bus ();

    adat_rx_lock_ctrl dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int         groups;  // 5-bit groups in the body before the sync
        int         skip;    // channel left out of the body (8 = none)
        int         sbits;   // bits presented together with the sync
        int         sch;     // channel word presented with the sync (8 = none)
        logic       good;
        logic       bad;
        logic [1:0] st;
        logic       lk;
        logic [15:0] ec;
    } vec_t;

    typedef struct {
        logic        ps;
        logic        good;
        logic        bad;
        logic [1:0]  st;
        logic        lk;
        logic [15:0] ec;
    } out_t;

    localparam int NVEC   = 19;
    localparam int PHASE1 = 15;

    vec_t vecs [NVEC];
    out_t exp_q [$];
    int   total_cnt = 0;
    int   bad_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_sync       = 1'b0;
        bus.i_valid      = 1'b0;
        bus.i_bit_count  = 3'd0;
        bus.i_data_valid = 1'b0;
        bus.i_channel    = 3'd0;
    endtask

    task automatic check_out(input string tag);
        out_t e;
        e = exp_q.pop_front();
        chk({tag, " parser_sync"}, 32'(bus.o_parser_sync), 32'(e.ps));
        chk({tag, " frame_good"},  32'(bus.o_frame_good),  32'(e.good));
        chk({tag, " frame_error"}, 32'(bus.o_frame_error), 32'(e.bad));
        chk({tag, " state"},       32'(bus.o_state),       32'(e.st));
        chk({tag, " locked"},      32'(bus.o_locked),      32'(e.lk));
        chk({tag, " err_count"},   32'(bus.o_err_count),   32'(e.ec));
        $display("%s: ps=%0b good=%0b err=%0b state=%0d locked=%0b errs=%0d", tag,
                 bus.o_parser_sync, bus.o_frame_good, bus.o_frame_error,
                 bus.o_state, bus.o_locked, bus.o_err_count);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic quiet;
        int   ch;
        quiet = 1'b1;
        for (int g = 0; g < v.groups; g++) begin
            idle_inputs();
            bus.i_valid     = 1'b1;
            bus.i_bit_count = 3'd5;
            ch = g / 5 - 1;
            if (g >= 5 && (g % 5) == 0 && ch < 8 && ch != v.skip) begin
                bus.i_data_valid = 1'b1;
                bus.i_channel    = 3'(ch);
            end
            cyc();
            if (bus.o_frame_good || bus.o_frame_error || !bus.o_parser_sync) quiet = 1'b0;
        end
        idle_inputs();
        bus.i_sync      = 1'b1;
        bus.i_valid     = (v.sbits != 0);
        bus.i_bit_count = 3'(v.sbits);
        if (v.sch < 8) begin
            bus.i_data_valid = 1'b1;
            bus.i_channel    = 3'(v.sch);
        end
        exp_q.push_back('{ps: 1'b0, good: v.good, bad: v.bad, st: v.st, lk: v.lk, ec: v.ec});
        cyc();
        idle_inputs();
        check_out(tag);
        if (v.groups > 0) chk({tag, " body quiet"}, 32'(quiet), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic ps_seen_low;
        vec_t v;

        //             groups skip sbits sch  good  bad   st    lk    ec
        vecs[0]  = '{  0, 8, 0, 8, 1'b0, 1'b0, 2'd1, 1'b0, 16'd0};
        vecs[1]  = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd1, 1'b0, 16'd0};
        vecs[2]  = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd1, 1'b0, 16'd0};
        vecs[3]  = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd1, 1'b0, 16'd0};
        vecs[4]  = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd2, 1'b1, 16'd0};
        vecs[5]  = '{ 48, 8, 0, 8, 1'b0, 1'b1, 2'd3, 1'b1, 16'd1};
        vecs[6]  = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd2, 1'b1, 16'd1};
        vecs[7]  = '{ 49, 3, 0, 8, 1'b0, 1'b1, 2'd3, 1'b1, 16'd2};
        vecs[8]  = '{ 49, 3, 0, 8, 1'b0, 1'b1, 2'd3, 1'b1, 16'd3};
        vecs[9]  = '{ 49, 3, 0, 8, 1'b0, 1'b1, 2'd0, 1'b0, 16'd4};
        vecs[10] = '{ 49, 8, 0, 8, 1'b0, 1'b0, 2'd1, 1'b0, 16'd4};
        vecs[11] = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd1, 1'b0, 16'd4};
        vecs[12] = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd1, 1'b0, 16'd4};
        vecs[13] = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd1, 1'b0, 16'd4};
        vecs[14] = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd2, 1'b1, 16'd4};
        vecs[15] = '{ 49, 7, 5, 7, 1'b1, 1'b0, 2'd2, 1'b1, 16'd5};
        vecs[16] = '{ 48, 8, 0, 8, 1'b1, 1'b0, 2'd2, 1'b1, 16'd5};
        vecs[17] = '{  0, 8, 0, 8, 1'b0, 1'b1, 2'd3, 1'b1, 16'd6};
        vecs[18] = '{ 49, 8, 0, 8, 1'b1, 1'b0, 2'd2, 1'b1, 16'd6};

        idle_inputs();
        i_rst = 1'b0;
        repeat (3) cyc();
        chk("reset parser_sync", 32'(bus.o_parser_sync), 32'(1));
        chk("reset state",       32'(bus.o_state),       32'(0));
        chk("reset locked",      32'(bus.o_locked),      32'(0));
        chk("reset err_count",   32'(bus.o_err_count),   32'(0));
        i_rst = 1'b1;
        cyc();

        for (int i = 0; i < PHASE1; i++) run_frame(vecs[i], $sformatf("frame %0d", i));

        // Silence while locked: the cycle counter must raise a bad close without a parser strobe.
        n = 0;
        ps_seen_low = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            cyc();
            if (!bus.o_parser_sync) ps_seen_low = 1'b1;
            if (bus.o_frame_error) begin
                n = k;
                break;
            end
        end
        exp_q.push_back('{ps: 1'b1, good: 1'b0, bad: 1'b1, st: 2'd3, lk: 1'b1, ec: 16'd5});
        chk("timeout latency", 32'(n), 32'(4096));
        chk("timeout no strobe", 32'(ps_seen_low), 32'(0));
        check_out("timeout");

        for (int i = PHASE1; i < NVEC; i++) run_frame(vecs[i], $sformatf("frame %0d", i));

        // Reset asserted part-way through a locked frame takes effect without a clock edge.
        for (int g = 0; g < 20; g++) begin
            bus.i_valid     = 1'b1;
            bus.i_bit_count = 3'd5;
            cyc();
        end
        idle_inputs();
        @(negedge i_clk);
        #1;
        i_rst = 1'b0;
        #1;
        chk("async rst state",       32'(bus.o_state),       32'(0));
        chk("async rst locked",      32'(bus.o_locked),      32'(0));
        chk("async rst parser_sync", 32'(bus.o_parser_sync), 32'(1));
        chk("async rst err_count",   32'(bus.o_err_count),   32'(0));
        $display("async reset: state=%0d locked=%0b ps=%0b errs=%0d",
                 bus.o_state, bus.o_locked, bus.o_parser_sync, bus.o_err_count);
        cyc();
        i_rst = 1'b1;
        cyc();

        v = '{49, 8, 0, 8, 1'b0, 1'b0, 2'd1, 1'b0, 16'd0};
        run_frame(v, "post-reset open");
        v = '{49, 8, 0, 8, 1'b1, 1'b0, 2'd1, 1'b0, 16'd0};
        run_frame(v, "post-reset good");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
